// File: rtl/stats_if.sv
// Report channel from the statistics producer to its consumer.
// The producer drives the fields and valid. The consumer returns ready.
interface stats_if #(
  parameter int W = 32
);
  logic         report_valid;
  logic         report_ready;
  logic [W-1:0] clk_count;
  logic [W-1:0] instr_count;
  logic [W-1:0] ipc_q;
  logic         overflow;

  modport master (
    output report_valid, clk_count, instr_count, ipc_q, overflow,
    input  report_ready
  );

  modport slave (
    input  report_valid, clk_count, instr_count, ipc_q, overflow,
    output report_ready
  );
endinterface

// File: rtl/stats_reporter.sv
// End-of-run statistics producer. It counts cycles and retired instructions.
// On halt it divides the two counts to get a fixed-point IPC and offers one report.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | program running, counters active
// DIV    | serial divide of (instr << FRAC) by cycles
// REPORT | report offered, waiting for handshake
// DONE   | report taken, fields still readable
module stats_reporter #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  logic     instr_retire,
  input  logic     halt,
  output logic     busy,
  stats_if.master  rpt
);
  localparam int NW = W + FRAC;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [2:0] {IDLE, RUN, DIV, REPORT, DONE} state_t;

  state_t         state, stateNext;
  logic [W-1:0]   clkCnt, instrCnt, ipcQ;
  logic [W-1:0]   clkNext, instrNext;
  logic           ovf, reportValid, clkSat, instrSat;
  logic [NW-1:0]  numer;
  logic [W-1:0]   rem;
  logic [W:0]     remTrial, remDiff;
  logic           qBit;
  logic [CW-1:0]  divCnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (halt) stateNext = DIV;
      DIV:     if (divCnt == '0) stateNext = REPORT;
      REPORT:  if (rpt.report_ready) stateNext = DONE;
      DONE:    if (start) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    clkSat    = &clkCnt;
    instrSat  = instr_retire & (&instrCnt);
    clkNext   = clkSat ? clkCnt : clkCnt + 1'b1;
    instrNext = (instr_retire && !instrSat) ? instrCnt + 1'b1 : instrCnt;
    remTrial  = {rem, numer[NW-1]};
    remDiff   = remTrial - {1'b0, clkCnt};
    qBit      = ~remDiff[W];
  end

  // Quotient bits shift into numer from the bottom, so numer ends up holding the quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkCnt      <= '0;
      instrCnt    <= '0;
      ipcQ        <= '0;
      ovf         <= 1'b0;
      reportValid <= 1'b0;
      numer       <= '0;
      rem         <= '0;
      divCnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            clkCnt   <= '0;
            instrCnt <= '0;
            ipcQ     <= '0;
            ovf      <= 1'b0;
          end
        end
        RUN: begin
          clkCnt   <= clkNext;
          instrCnt <= instrNext;
          if (clkSat || instrSat) ovf <= 1'b1;
          if (halt) begin
            numer  <= {instrNext, {FRAC{1'b0}}};
            rem    <= '0;
            divCnt <= CW'(NW);
          end
        end
        DIV: begin
          if (divCnt != '0) begin
            numer  <= {numer[NW-2:0], qBit};
            rem    <= qBit ? remDiff[W-1:0] : remTrial[W-1:0];
            divCnt <= divCnt - 1'b1;
          end else begin
            ipcQ        <= numer[W-1:0];
            reportValid <= 1'b1;
          end
        end
        REPORT: begin
          if (rpt.report_ready) reportValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy             = (state == RUN) || (state == DIV) || (state == REPORT);
  assign rpt.report_valid = reportValid;
  assign rpt.clk_count    = clkCnt;
  assign rpt.instr_count  = instrCnt;
  assign rpt.ipc_q        = ipcQ;
  assign rpt.overflow     = ovf;
endmodule
